// File: rtl/simon_iterative_core_if.sv
// Key and data handshake bundle for simon_iterative_core; the core is the slave side.
interface simon_iterative_core_if #(
  parameter int N = 64,
  parameter int M = 3
);
  logic             newKey;
  logic [M*N-1:0]   key;
  logic             ldKey;
  logic             doneKey;
  logic             newData;
  logic             enc_dec;
  logic [2*N-1:0]   plain;
  logic             ldData;
  logic             doneData;
  logic             readData;
  logic [2*N-1:0]   cipher;

  modport master (
    output newKey, key, newData, enc_dec, plain, readData,
    input  ldKey, doneKey, ldData, doneData, cipher
  );

  modport slave (
    input  newKey, key, newData, enc_dec, plain, readData,
    output ldKey, doneKey, ldData, doneData, cipher
  );
endinterface

// File: rtl/simon_iterative_core.sv
// Iterative SIMON 2N/MN core: key expansion into a round-key store, then one block per request.
// Optional macro SIMON_DUAL_ROUND_EN: two cascaded rounds per clock in RUN.
//
// state | meaning
// KIDLE | key FSM waiting for newKey
// KEXP  | expanding round keys, one word per cycle
// IDLE  | data FSM waiting for newData
// RUN   | applying cipher rounds
// DONE  | cipher valid, waiting for readData
module simon_iterative_core #(
  parameter int N    = 64,
  parameter int M    = 3,
  parameter int T    = 69,
  parameter int ZSEL = 3
) (
  input logic clk,
  input logic nR,
  simon_iterative_core_if.slave bus
);

  localparam int CW = $clog2(T);

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [61:0] ZS = (ZSEL == 0) ? Z0 : (ZSEL == 1) ? Z1 :
                               (ZSEL == 2) ? Z2 : (ZSEL == 3) ? Z3 : Z4;

  typedef enum logic {KIDLE, KEXP} kstate_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} dstate_t;

  kstate_t        kstate;
  dstate_t        dstate;
  logic [N-1:0]   rk [T];
  logic [CW-1:0]  kcnt;
  logic [5:0]     zidx;
  logic [N-1:0]   x, y;
  logic           encr;
  logic [CW-1:0]  rnd;
  logic           ld_key_q, done_key_q, ld_data_q, done_data_q;
  logic [2*N-1:0] cipher_q;

  logic           key_accept, data_accept;
  logic [N-1:0]   tmp, k_new;
  logic [2*N-1:0] r1, nxt;
  logic           last_one, finish;
  logic [CW-1:0]  rnd_step;

  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int s);
    return (a << s) | (a >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int s);
    return rol(a, N - s);
  endfunction

  function automatic logic [N-1:0] f_simon(input logic [N-1:0] a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction

  function automatic logic [2*N-1:0] round_step(input logic e, input logic [2*N-1:0] xy,
                                                input logic [N-1:0] k);
    logic [N-1:0] xa, ya;
    xa = xy[2*N-1:N];
    ya = xy[N-1:0];
    if (e) return {ya ^ f_simon(xa) ^ k, xa};
    else   return {ya, xa ^ f_simon(ya) ^ k};
  endfunction

  // Key load wins a tie so pending data always waits for the fresh schedule.
  assign key_accept  = bus.newKey && (kstate == KIDLE) && (dstate == IDLE);
  assign data_accept = bus.newData && (dstate == IDLE) && done_key_q &&
                       (kstate == KIDLE) && !key_accept;

  always_comb begin
    tmp = ror(rk[kcnt - CW'(1)], 3);
    if (M == 4) tmp = tmp ^ rk[kcnt - CW'(3)];
    tmp = tmp ^ ror(tmp, 1);
    k_new = ~rk[kcnt - CW'(M)] ^ tmp ^ N'(3);
    k_new[0] = k_new[0] ^ ZS[6'd61 - zidx];
  end

`ifdef SIMON_DUAL_ROUND_EN
  logic [CW-1:0]  idx2;
  logic [2*N-1:0] r2;

  always_comb begin
    last_one = encr ? (rnd == CW'(T - 1)) : (rnd == '0);
    r1 = round_step(encr, {x, y}, rk[rnd]);
    idx2 = rnd;
    if (!last_one) idx2 = encr ? rnd + CW'(1) : rnd - CW'(1);
    r2 = round_step(encr, r1, rk[idx2]);
    nxt = last_one ? r1 : r2;
    finish = last_one || (encr ? (rnd == CW'(T - 2)) : (rnd == CW'(1)));
    rnd_step = CW'(2);
  end
`else
  always_comb begin
    last_one = encr ? (rnd == CW'(T - 1)) : (rnd == '0);
    r1 = round_step(encr, {x, y}, rk[rnd]);
    nxt = r1;
    finish = last_one;
    rnd_step = CW'(1);
  end
`endif

  // Round-key store carries no reset; doneKey alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (key_accept) begin
      for (int i = 0; i < M; i++) rk[i] <= bus.key[i*N +: N];
    end else if (kstate == KEXP) begin
      rk[kcnt] <= k_new;
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      kstate     <= KIDLE;
      kcnt       <= '0;
      zidx       <= '0;
      ld_key_q   <= 1'b0;
      done_key_q <= 1'b0;
    end else begin
      ld_key_q <= 1'b0;
      case (kstate)
        KIDLE: begin
          if (key_accept) begin
            ld_key_q   <= 1'b1;
            done_key_q <= 1'b0;
            kcnt       <= CW'(M);
            zidx       <= '0;
            kstate     <= KEXP;
          end
        end
        KEXP: begin
          zidx <= (zidx == 6'd61) ? 6'd0 : zidx + 6'd1;
          if (kcnt == CW'(T - 1)) begin
            done_key_q <= 1'b1;
            kstate     <= KIDLE;
          end else begin
            kcnt <= kcnt + CW'(1);
          end
        end
        default: kstate <= KIDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      dstate      <= IDLE;
      x           <= '0;
      y           <= '0;
      encr        <= 1'b0;
      rnd         <= '0;
      ld_data_q   <= 1'b0;
      done_data_q <= 1'b0;
      cipher_q    <= '0;
    end else begin
      ld_data_q <= 1'b0;
      case (dstate)
        IDLE: begin
          if (data_accept) begin
            x         <= bus.plain[2*N-1:N];
            y         <= bus.plain[N-1:0];
            encr      <= bus.enc_dec;
            rnd       <= bus.enc_dec ? '0 : CW'(T - 1);
            ld_data_q <= 1'b1;
            dstate    <= RUN;
          end
        end
        RUN: begin
          x <= nxt[2*N-1:N];
          y <= nxt[N-1:0];
          if (finish) begin
            cipher_q    <= nxt;
            done_data_q <= 1'b1;
            dstate      <= DONE;
          end else begin
            rnd <= encr ? rnd + rnd_step : rnd - rnd_step;
          end
        end
        DONE: begin
          if (bus.readData) begin
            done_data_q <= 1'b0;
            dstate      <= IDLE;
          end
        end
        default: dstate <= IDLE;
      endcase
    end
  end

  assign bus.ldKey    = ld_key_q;
  assign bus.doneKey  = done_key_q;
  assign bus.ldData   = ld_data_q;
  assign bus.doneData = done_data_q;
  assign bus.cipher   = cipher_q;

endmodule

// File: tb/tb_simon_iterative_core.sv
// Directed bench for simon_iterative_core: 128/192 and 32/64 instances, table vectors plus
// arbitration and mid-run reset sequences.
module tb_simon_iterative_core;

`ifdef SIMON_DUAL_ROUND_EN
  localparam int LAT_A = 35;
  localparam int LAT_B = 16;
`else
  localparam int LAT_A = 69;
  localparam int LAT_B = 32;
`endif

  localparam logic [191:0] KEY_A = 192'h17161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT_A  = 128'h206572656874206e6568772065626972;
  localparam logic [127:0] CT_A  = 128'hc4ac61effcdc0d4f6c9c8d6e2597b85b;
  localparam logic [63:0]  KEY_B = 64'h1918111009080100;
  localparam logic [127:0] PT_B  = 128'h65656877;
  localparam logic [127:0] CT_B  = 128'hc69be9bb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nR;
  logic [1:0] new_key, new_data, enc_dec, read_data;
  logic [191:0] key_a;
  logic [63:0]  key_b;
  logic [127:0] plain_a;
  logic [31:0]  plain_b;
  logic [1:0] ld_key, done_key, ld_data, done_data;
  logic [127:0] cipher_out [2];

  simon_iterative_core_if #(.N(64), .M(3)) bus_a ();
  simon_iterative_core_if #(.N(16), .M(4)) bus_b ();

  simon_iterative_core #(.N(64), .M(3), .T(69), .ZSEL(3)) dut_a (.clk(clk), .nR(nR), .bus(bus_a));
  simon_iterative_core #(.N(16), .M(4), .T(32), .ZSEL(0)) dut_b (.clk(clk), .nR(nR), .bus(bus_b));

  assign bus_a.newKey   = new_key[0];
  assign bus_a.key      = key_a;
  assign bus_a.newData  = new_data[0];
  assign bus_a.enc_dec  = enc_dec[0];
  assign bus_a.plain    = plain_a;
  assign bus_a.readData = read_data[0];
  assign bus_b.newKey   = new_key[1];
  assign bus_b.key      = key_b;
  assign bus_b.newData  = new_data[1];
  assign bus_b.enc_dec  = enc_dec[1];
  assign bus_b.plain    = plain_b;
  assign bus_b.readData = read_data[1];

  assign ld_key[0]     = bus_a.ldKey;
  assign ld_key[1]     = bus_b.ldKey;
  assign done_key[0]   = bus_a.doneKey;
  assign done_key[1]   = bus_b.doneKey;
  assign ld_data[0]    = bus_a.ldData;
  assign ld_data[1]    = bus_b.ldData;
  assign done_data[0]  = bus_a.doneData;
  assign done_data[1]  = bus_b.doneData;
  assign cipher_out[0] = bus_a.cipher;
  assign cipher_out[1] = {96'b0, bus_b.cipher};

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int           core;
    logic         enc;
    logic [127:0] pt;
    logic [127:0] ct;
    string        name;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic load_key(input int c, input logic [191:0] k, input int lat, input string name);
    int n;
    bit seen;
    if (c == 0) key_a = k;
    else key_b = k[63:0];
    new_key[c] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = ld_key[c];
    end
    new_key[c] = 1'b0;
    check({name, "_ldKey"}, 128'(seen), 128'd1);
    check({name, "_doneKey_low"}, 128'(done_key[c]), 128'd0);
    @(negedge clk);
    n = 1;
    check({name, "_ldKey_pulse"}, 128'(ld_key[c]), 128'd0);
    while (!done_key[c] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_key_latency"}, 128'(n), 128'(lat));
  endtask

  // Entered on the negedge where ldData is first seen high.
  task automatic finish_data(input int c, input logic [127:0] exp, input int lat, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check({name, "_ldData_pulse"}, 128'(ld_data[c]), 128'd0);
    end while (!done_data[c] && n < 300);
    check({name, "_latency"}, 128'(n), 128'(lat));
    check({name, "_cipher"}, cipher_out[c], exp);
    read_data[c] = 1'b1;
    @(negedge clk);
    read_data[c] = 1'b0;
    check({name, "_doneData_fall"}, 128'(done_data[c]), 128'd0);
    check({name, "_cipher_hold"}, cipher_out[c], exp);
  endtask

  task automatic run_data(input int c, input logic enc, input logic [127:0] pt,
                          input logic [127:0] exp, input int lat, input string name);
    bit seen;
    if (c == 0) plain_a = pt;
    else plain_b = pt[31:0];
    enc_dec[c] = enc;
    new_data[c] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = ld_data[c];
    end
    new_data[c] = 1'b0;
    check({name, "_ldData"}, 128'(seen), 128'd1);
    finish_data(c, exp, lat, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ld_count;
    bit seen;

    tbl[0] = '{core: 0, enc: 1'b1, pt: PT_A, ct: CT_A, name: "a_enc"};
    tbl[1] = '{core: 0, enc: 1'b0, pt: CT_A, ct: PT_A, name: "a_dec"};
    tbl[2] = '{core: 1, enc: 1'b1, pt: PT_B, ct: CT_B, name: "b_enc"};
    tbl[3] = '{core: 1, enc: 1'b0, pt: CT_B, ct: PT_B, name: "b_dec"};

    nR = 1'b0;
    new_key = '0;
    new_data = '0;
    enc_dec = '0;
    read_data = '0;
    key_a = '0;
    key_b = '0;
    plain_a = '0;
    plain_b = '0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check("rst_ldKey", 128'(ld_key[c]), 128'd0);
      check("rst_doneKey", 128'(done_key[c]), 128'd0);
      check("rst_ldData", 128'(ld_data[c]), 128'd0);
      check("rst_doneData", 128'(done_data[c]), 128'd0);
      check("rst_cipher", cipher_out[c], 128'd0);
    end
    nR = 1'b1;
    @(negedge clk);

    load_key(0, KEY_A, 66, "a_key");
    load_key(1, {128'd0, KEY_B}, 28, "b_key");

    for (int i = 0; i < 4; i++) begin
      run_data(tbl[i].core, tbl[i].enc, tbl[i].pt, tbl[i].ct,
               (tbl[i].core == 0) ? LAT_A : LAT_B, tbl[i].name);
    end

    // Simultaneous key and data requests: key wins, data follows the new doneKey.
    plain_a = PT_A;
    enc_dec[0] = 1'b1;
    key_a = KEY_A;
    new_key[0] = 1'b1;
    new_data[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ld_key[0];
    end
    new_key[0] = 1'b0;
    check("arb_ldKey", 128'(seen), 128'd1);
    check("arb_ldData_held", 128'(ld_data[0]), 128'd0);
    check("arb_doneKey_low", 128'(done_key[0]), 128'd0);
    n = 0;
    while (!ld_data[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    new_data[0] = 1'b0;
    check("arb_ldData_delay", 128'(n), 128'd67);
    finish_data(0, CT_A, LAT_A, "arb");

    // Reset mid-RUN, then data must wait for a fresh key load.
    plain_a = PT_A;
    enc_dec[0] = 1'b1;
    new_data[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ld_data[0];
    end
    new_data[0] = 1'b0;
    check("rr_ldData", 128'(seen), 128'd1);
    repeat (30) @(negedge clk);
    nR = 1'b0;
    #1;
    check("rr_ldKey", 128'(ld_key[0]), 128'd0);
    check("rr_doneKey", 128'(done_key[0]), 128'd0);
    check("rr_ldData0", 128'(ld_data[0]), 128'd0);
    check("rr_doneData", 128'(done_data[0]), 128'd0);
    check("rr_cipher", cipher_out[0], 128'd0);
    @(negedge clk);
    nR = 1'b1;
    new_data[0] = 1'b1;
    ld_count = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ld_data[0]) ld_count++;
    end
    check("rr_data_ignored", 128'(ld_count), 128'd0);
    check("rr_doneData_idle", 128'(done_data[0]), 128'd0);
    load_key(0, KEY_A, 66, "rr_key");
    n = 0;
    while (!ld_data[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    new_data[0] = 1'b0;
    check("rr_ldData_after_key", 128'(n), 128'd1);
    finish_data(0, CT_A, LAT_A, "rr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simon_iterative_core.md
# simon_iterative_core

Parametrised, iterative SIMON block-cipher core covering every SIMON 2N/MN variant: 32/64 through 128/256. It expands the key once into an internal round-key store, then encrypts or decrypts one block per request at one round per clock. It has a newKey/ldKey/doneKey key handshake and a newData/ldData/doneData/readData data handshake. It replaces the fixed-variant SIMON cores as the single cipher engine instantiated by the top-level wrappers.

## Interface
- N, 64, word size in bits; legal values 16, 24, 32, 48, 64.
- M, 3, key words; legal values 2, 3, 4.
- T, 69, round count; must match the (N,M) variant.
- ZSEL, 3, z-sequence index 0..4 used by the key schedule.
- clk  input  1  single clock, rising edge.
- nR  input  1  asynchronous, active-low reset.
- newKey  input  1  level request to load `key`.
- key  input  M*N  key words; word i = key[i*N +: N], word 0 = k[0].
- ldKey  output  1  one-cycle pulse: key request accepted.
- doneKey  output  1  round-key store valid.
- newData  input  1  level request to process `plain`.
- enc_dec  input  1  1 = encrypt, 0 = decrypt; sampled at accept.
- plain  input  2N  input block; x = plain[2N-1:N], y = plain[N-1:0].
- ldData  output  1  one-cycle pulse: data request accepted.
- doneData  output  1  `cipher` valid.
- readData  input  1  consumer acknowledge.
- cipher  output  2N  result block, same x/y packing as `plain`.

## Operation
- Reset: all outputs 0, both FSMs in IDLE, round-key store contents don't-care.
- Key FSM states: KIDLE, KEXP.
  - Accept condition: newKey=1 in KIDLE while the data FSM is IDLE.
  - On accept: latch k[0..M-1], pulse ldKey, clear doneKey, enter KEXP.
  - KEXP computes k[i] for i = M..T-1, one word per cycle.
  - tmp = ror3(k[i-1]); if M==4, tmp ^= k[i-3]; tmp ^= ror1(tmp).
  - k[i] = ~k[i-M] ^ tmp ^ z_ZSEL[(i-M) mod 62] ^ 3.
  - After the last word: doneKey=1, return to KIDLE.
- Data FSM states: IDLE, RUN, DONE.
  - Accept condition: newData=1 in IDLE with doneKey=1 and the key FSM in KIDLE.
  - On accept: latch x, y and enc_dec; pulse ldData; enter RUN.
  - f(a) = (rol1 a & rol8 a) ^ rol2 a.
  - Encrypt round i = 0..T-1: x' = y ^ f(x) ^ k[i], y' = x.
  - Decrypt round i = T-1..0: y' = x ^ f(y) ^ k[i], x' = y.
  - After the final round: cipher = {x,y}, doneData=1, enter DONE.
  - DONE: cipher and doneData hold until readData=1 is sampled. On that edge doneData falls and the FSM enters IDLE.
- All shifts are rotates modulo N. The round counter is $clog2(T) bits and never exceeds T-1.
- newData and newKey are levels. A request still high when its FSM returns to idle is accepted again. The requester must drop it after seeing ld*.
- newKey during RUN/DONE, or newData during KEXP / with doneKey=0, is held off (not lost) until its accept condition holds.
- Simultaneous newKey and newData in idle: the key request wins, and data waits for the new doneKey.
- nR low mid-operation aborts immediately. The previous round keys are invalid and doneKey=0.

## Timing
- Key accept edge K0: ldKey high for the cycle after K0, doneKey low from K0.
- doneKey rises after edge K(T-M). That is 66 cycles for 128/192.
- Data accept edge E0: ldData high for the cycle after E0. Rounds occur on edges E1..ET.
- doneData and cipher are valid after ET, a latency of T cycles.
- readData sampled at edge R: doneData low after R. The earliest next accept is edge R+1.
- cipher keeps its last value until the next DONE entry.

## Configuration
- SIMON_DUAL_ROUND_EN defined: two cascaded rounds per clock, so RUN lasts ceil(T/2) cycles (35 for T=69).
  - For odd T, the final RUN cycle applies one round only.
  - The key schedule still produces one word per cycle.
- SIMON_DUAL_ROUND_EN undefined: one round per clock, as above.
- The handshakes are identical in both builds.

## Test plan
- 128/192 (N=64, M=3, T=69, ZSEL=3), key 0x17161514131211100f0e0d0c0b0a09080706050403020100, encrypt 0x206572656874206e6568772065626972 -> cipher 0xc4ac61effcdc0d4f6c9c8d6e2597b85b, doneData exactly 69 cycles after accept.
- Same key, enc_dec=0, plain 0xc4ac61effcdc0d4f6c9c8d6e2597b85b -> cipher 0x206572656874206e6568772065626972.
- 32/64 (N=16, M=4, T=32, ZSEL=0), key 0x1918111009080100, plain 0x65656877 -> 0xc69be9bb. Decrypting 0xc69be9bb returns 0x65656877.
- newData high with doneKey=0 and newKey raised on the same edge -> key accepted first, ldData only after doneKey (66 cycles), final result still correct.
- nR pulsed low mid-RUN (round 30) -> all outputs 0 immediately, doneKey=0, newData ignored until a fresh key load completes.
- Build with SIMON_DUAL_ROUND_EN -> 128/192 vector gives the same cipher with doneData 35 cycles after accept.
